// File: rtl/ram_burst.sv
// ram_burst: single-port synchronous RAM with a burst command interface,
// byte-lane write strobes and a hardware clear sequence after every reset.
// A command (read or write, start address, beats-1) is accepted with a
// valid/ready handshake in IDLE. The burst then streams req_len+1 beats
// at consecutive addresses that wrap modulo DEPTH.
module ram_burst #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cen,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                rlast,
  output logic                busy,
  output logic                init_done
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len;

  logic [DATA_W-1:0] mem [DEPTH];

  logic rd_issue;
  logic wr_beat;
  logic last_beat;

  // Handshake and beat qualifiers, all derived from the current state and cen.
  assign req_ready = (state == S_IDLE) && cen;
  assign wready    = (state == S_WRITE) && cen;
  assign busy      = (state != S_IDLE);
  assign rd_issue  = (state == S_READ) && cen;
  assign wr_beat   = wready && wvalid;
  assign last_beat = (beat_cnt == len);

  // Burst sequencer: clear sweep, command capture, beat/address counting and
  // the registered read-return path.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, exactly like real flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_CLEAR;
      addr      <= '0;
      beat_cnt  <= '0;
      len       <= '0;
      init_done <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
    end else begin
      // Read return: data only while a read was issued last cycle, else 0.
      rvalid <= rd_issue;
      rlast  <= rd_issue && last_beat;
      rdata  <= rd_issue ? mem[addr] : '0;

      case (state)
        S_CLEAR: begin
          addr <= addr + ADDR_W'(1);
          if (&addr) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr     <= req_addr;
            len      <= req_len;
            beat_cnt <= '0;
            state    <= req_wen ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr     <= addr + ADDR_W'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (wr_beat) begin
            addr     <= addr + ADDR_W'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) state <= S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Storage write port: zero fill during CLEAR, strobed lane writes in WRITE.
  // NOTE: the array deliberately has no reset branch; a reset on a memory
  // prevents RAM inference, so the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[addr] <= '0;
    end else if (wr_beat) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
